// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises debounced A/B phases, classifies Gray-code
// transitions and drives a saturating cursor position with one-cycle step pulses.
`timescale 1ns/1ps

module quad_decoder #(
  parameter int POS_W    = 10,
  parameter int POS_MAX  = 639,
  parameter int POS_INIT = 320,
  parameter int DETENT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             step_up,
  output logic             step_dn,
  output logic             err
);

  localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);
  localparam logic [1:0]       REST       = 2'b11;

  typedef enum logic [1:0] {
    MOVE_IDLE,
    MOVE_CW,
    MOVE_CCW,
    MOVE_ILLEGAL
  } move_e;

  logic [1:0]        sync1;
  logic [1:0]        s2;
  logic [1:0]        prev;
  logic [1:0]        arm_cnt;
  logic              armed;
  move_e             move;

  logic signed [3:0] acc;
  logic signed [3:0] acc_next;
  logic signed [3:0] acc_step;
  logic [POS_W-1:0]  pos_next;
  logic              up_next;
  logic              dn_next;
  logic              err_next;

  // Arming lets the synchroniser and prev flush out of their reset value
  // before any transition is judged, so a non-rest input at release is not
  // mistaken for motion or an illegal jump.
  assign armed = (arm_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others (the sync chain depends on it).
    if (!rst_n) begin
      sync1   <= REST;
      s2      <= REST;
      prev    <= REST;
      arm_cnt <= 2'd0;
    end else begin
      sync1 <= {a_in, b_in};
      s2    <= sync1;
      prev  <= s2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns move and no latch is inferred.
    move = MOVE_IDLE;
    if (s2 != prev) begin
      if ((s2 ^ prev) == 2'b11) begin
        move = MOVE_ILLEGAL;
      end else begin
        case ({prev, s2})
          4'b1110, 4'b1000, 4'b0001, 4'b0111: move = MOVE_CW;
          default:                            move = MOVE_CCW;
        endcase
      end
    end
  end

  always_comb begin
    acc_next = acc;
    acc_step = acc;
    err_next = err;
    up_next  = 1'b0;
    dn_next  = 1'b0;
    pos_next = pos;

    if (armed) begin
      case (move)
        MOVE_CW, MOVE_CCW: begin
          if (DETENT != 0) begin
            acc_step = (move == MOVE_CW) ? acc + 4'sd1 : acc - 4'sd1;
            if (s2 == REST) begin
              // Only a full detent counts; partial or reversed ones are dropped.
              acc_next = 4'sd0;
              up_next  = (acc_step == 4'sd4);
              dn_next  = (acc_step == -4'sd4);
            end else begin
              acc_next = acc_step;
            end
          end else begin
            up_next = (move == MOVE_CW);
            dn_next = (move == MOVE_CCW);
          end
        end
        MOVE_ILLEGAL: begin
          acc_next = 4'sd0;
          err_next = 1'b1;
        end
        default: ;
      endcase
    end

    if (clr) begin
      acc_next = 4'sd0;
      err_next = 1'b0;
      up_next  = 1'b0;
      dn_next  = 1'b0;
    end

    // The pulse is still issued at a bound; only the position saturates.
    if (clr)                            pos_next = POS_INIT_V;
    else if (up_next && pos < POS_MAX_V) pos_next = pos + POS_W'(1);
    else if (dn_next && pos != '0)       pos_next = pos - POS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos     <= POS_INIT_V;
      acc     <= 4'sd0;
      err     <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      pos     <= pos_next;
      acc     <= acc_next;
      err     <= err_next;
      step_up <= up_next;
      step_dn <= dn_next;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: four instances (default, POS_INIT=639,
// POS_INIT=0, DETENT=0) share one stimulus stream with hand-computed results.
`timescale 1ns/1ps

module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       clr;

  logic [9:0] pos_v [4];
  logic [3:0] up_v;
  logic [3:0] dn_v;
  logic [3:0] err_v;

  int up_cnt [4];
  int dn_cnt [4];
  int up_mark [4];
  int dn_mark [4];
  int both_cnt;

  int tests;
  int failed;

  always #1 clk = ~clk;

  quad_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .clr(clr),
    .pos(pos_v[0]), .step_up(up_v[0]), .step_dn(dn_v[0]), .err(err_v[0])
  );

  quad_decoder #(.POS_INIT(639)) u_hi (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .clr(clr),
    .pos(pos_v[1]), .step_up(up_v[1]), .step_dn(dn_v[1]), .err(err_v[1])
  );

  quad_decoder #(.POS_INIT(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .clr(clr),
    .pos(pos_v[2]), .step_up(up_v[2]), .step_dn(dn_v[2]), .err(err_v[2])
  );

  quad_decoder #(.DETENT(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .clr(clr),
    .pos(pos_v[3]), .step_up(up_v[3]), .step_dn(dn_v[3]), .err(err_v[3])
  );

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as extra.
  initial begin
    both_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      up_cnt[i] = 0;
      dn_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (up_v[i] === 1'b1) up_cnt[i] = up_cnt[i] + 1;
      if (dn_v[i] === 1'b1) dn_cnt[i] = dn_cnt[i] + 1;
      if (up_v[i] === 1'b1 && dn_v[i] === 1'b1) both_cnt = both_cnt + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s);
    @(negedge clk);
    {a, b} = s;
    repeat (100) @(posedge clk);
  endtask

  task automatic mark();
    for (int i = 0; i < 4; i++) begin
      up_mark[i] = up_cnt[i];
      dn_mark[i] = dn_cnt[i];
    end
  endtask

  task automatic check_steps(input string tag, input int idx, input int exp_up,
                             input int exp_dn, input int exp_pos);
    check($sformatf("%s[%0d].up", tag, idx), up_cnt[idx] - up_mark[idx], exp_up);
    check($sformatf("%s[%0d].dn", tag, idx), dn_cnt[idx] - dn_mark[idx], exp_dn);
    check($sformatf("%s[%0d].pos", tag, idx), int'(pos_v[idx]), exp_pos);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    {a, b} = 2'b11;
    clr    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.pos0", int'(pos_v[0]), 320);
    check("rst.pos1", int'(pos_v[1]), 639);
    check("rst.pos2", int'(pos_v[2]), 0);
    check("rst.pos3", int'(pos_v[3]), 320);
    check("rst.up", int'(up_v), 0);
    check("rst.dn", int'(dn_v), 0);
    check("rst.err", int'(err_v), 0);
    rst_n = 1'b1;
    drive(2'b11);

    // Full CW detent, with latency of the final transition checked cycle by cycle
    mark();
    drive(2'b10);
    drive(2'b00);
    drive(2'b01);
    @(negedge clk);
    {a, b} = 2'b11;
    @(negedge clk);
    check("lat.n", int'(up_v[0]), 0);
    @(negedge clk);
    check("lat.n1", int'(up_v[0]), 0);
    @(negedge clk);
    check("lat.n2", int'(up_v[0]), 1);
    check("lat.n2pos", int'(pos_v[0]), 321);
    @(negedge clk);
    check("lat.n3", int'(up_v[0]), 0);
    repeat (96) @(posedge clk);
    check_steps("cw", 0, 1, 0, 321);
    check_steps("cw", 1, 1, 0, 639);
    check_steps("cw", 2, 1, 0, 1);
    check_steps("cw", 3, 4, 0, 324);
    check("cw.err", int'(err_v), 0);

    // Full CCW detent
    mark();
    drive(2'b01);
    drive(2'b00);
    drive(2'b10);
    drive(2'b11);
    check_steps("ccw", 0, 0, 1, 320);
    check_steps("ccw", 1, 0, 1, 638);
    check_steps("ccw", 2, 0, 1, 0);
    check_steps("ccw", 3, 0, 4, 320);

    // Partial detent that reverses back to rest
    mark();
    drive(2'b10);
    drive(2'b00);
    drive(2'b10);
    drive(2'b11);
    check_steps("part", 0, 0, 0, 320);
    check_steps("part", 3, 2, 2, 320);
    check("part.err", int'(err_v[0]), 0);

    // Second CCW detent: lower bound holds but the pulse is still issued
    mark();
    drive(2'b01);
    drive(2'b00);
    drive(2'b10);
    drive(2'b11);
    check_steps("sat", 0, 0, 1, 319);
    check_steps("sat", 2, 0, 1, 0);
    check_steps("sat", 1, 0, 1, 637);

    // Illegal double-bit jump, sticky err, then clear
    mark();
    drive(2'b00);
    check("ill.err", int'(err_v), 4'hF);
    check_steps("ill", 0, 0, 0, 319);
    check_steps("ill", 3, 0, 0, 316);
    mark();
    drive(2'b01);
    drive(2'b11);
    check_steps("ret", 0, 0, 0, 319);
    check_steps("ret", 3, 2, 0, 318);
    check("ret.err", int'(err_v[0]), 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr.err", int'(err_v), 0);
    check("clr.pos0", int'(pos_v[0]), 320);
    check("clr.pos1", int'(pos_v[1]), 639);
    check("clr.pos2", int'(pos_v[2]), 0);
    check("clr.pos3", int'(pos_v[3]), 320);
    repeat (10) @(posedge clk);

    // Reset mid-detent: progress lost, completing the detent yields nothing
    drive(2'b10);
    @(negedge clk);
    {a, b} = 2'b00;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #0.2;
    check("mid.pos0", int'(pos_v[0]), 320);
    check("mid.pos3", int'(pos_v[3]), 320);
    check("mid.up", int'(up_v), 0);
    check("mid.dn", int'(dn_v), 0);
    check("mid.err", int'(err_v), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    mark();
    drive(2'b01);
    drive(2'b11);
    check_steps("rel", 0, 0, 0, 320);
    check_steps("rel", 3, 2, 0, 322);
    check("rel.err", int'(err_v), 0);

    check("excl", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
